// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first parallel-to-serial shifter with bit strobes and a trailing word-delimiter strobe
module piso_serializer #(
  parameter int WIDTH = 32,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             serial_out,
  output logic             TB,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DELIM} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             done_q, done_d;
  logic             wrap, last;
  assign wrap       = div_cnt_q == DW'(CLKS_PER_BIT - 1);
  assign last       = bit_cnt_q == BW'(WIDTH - 1);
  assign din_ready  = state_q == IDLE && !reset;
  assign busy       = state_q != IDLE;
  assign TB         = busy && div_cnt_q == '0;
  assign serial_out = state_q == SHIFT && shreg_q[WIDTH-1];
  assign done       = done_q;
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    done_d    = 1'b0;
    if (state_q == IDLE) begin
      if (din_valid) begin
        state_d   = SHIFT;
        shreg_d   = din;
        bit_cnt_d = '0;
        div_cnt_d = '0;
      end
    end else begin
      div_cnt_d = wrap ? '0 : div_cnt_q + DW'(1);
      if (wrap && state_q == SHIFT) begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = last ? '0 : bit_cnt_q + BW'(1);
        state_d   = last ? DELIM : SHIFT;
      end
      if (wrap && state_q == DELIM) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for two WIDTH=8 instances (bit period 1 and 4)
module tb_piso_serializer;
  typedef struct {
    logic [7:0] w;
    int         due;
  } exp_t;
  logic       clk = 1'b0;
  int         cyc = 0;
  logic       rst [2];
  logic [7:0] din [2];
  logic       vld [2];
  logic       rdy [2];
  logic       so  [2];
  logic       tb  [2];
  logic       busy[2];
  logic       done[2];
  exp_t       q0[$];
  exp_t       q1[$];
  int         checks = 0;
  int         fails = 0;
  bit         fin = 1'b0;
  bit         fin_seen = 1'b0;
  logic [7:0] bits[2];
  int         tbn[2], first_tb[2], last_tb[2];
  bit         perr[2], delim[2], cur[2], rst_d[2];
  int         ta, tb_acc, tr;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(1)) u0 (
    .clk(clk), .reset(rst[0]), .din(din[0]), .din_valid(vld[0]), .din_ready(rdy[0]),
    .serial_out(so[0]), .TB(tb[0]), .busy(busy[0]), .done(done[0])
  );
  piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(4)) u1 (
    .clk(clk), .reset(rst[1]), .din(din[1]), .din_valid(vld[1]), .din_ready(rdy[1]),
    .serial_out(so[1]), .TB(tb[1]), .busy(busy[1]), .done(done[1])
  );
  function automatic int per(input int i);
    return i == 0 ? 1 : 4;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push(input int i, input logic [7:0] w, input int due);
    exp_t e;
    e.w = w;
    e.due = due;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic send(input int i, input logic [7:0] w, input int due_ovr, input bit expect_done, output int t);
    int n;
    din[i] = w;
    vld[i] = 1'b1;
    n = 0;
    t = -1;
    while (t < 0 && n < 300) begin
      @(negedge clk);
      if (rdy[i]) t = cyc;
      n++;
    end
    if (t < 0) begin
      $display("FAIL accept_timeout: inst %0d word %0h never accepted", i, w);
      $fatal(1);
    end
    if (expect_done) push(i, w, due_ovr >= 0 ? due_ovr : t + 1 + 9 * per(i));
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
    din[i] = ~w;
  endtask
  task automatic mon(input int i);
    exp_t e;
    bit   have;
    if (rst_d[i]) chk("post_reset_outputs", int'({tb[i], so[i], busy[i], done[i], rdy[i]}), int'({4'b0, !rst[i]}));
    if (rst[i]) begin
      tbn[i] = 0;
      perr[i] = 1'b0;
      bits[i] = '0;
    end else begin
      if (busy[i] && rdy[i]) perr[i] = 1'b1;
      if (tb[i] && !busy[i]) perr[i] = 1'b1;
      if (tb[i]) begin
        if (tbn[i] == 0) first_tb[i] = cyc;
        else if (cyc - last_tb[i] != per(i)) perr[i] = 1'b1;
        last_tb[i] = cyc;
        if (tbn[i] < 8) bits[i] = {bits[i][6:0], so[i]};
        else delim[i] = so[i];
        cur[i] = so[i];
        tbn[i]++;
      end else if (busy[i] && so[i] != cur[i]) perr[i] = 1'b1;
      if (done[i]) begin
        have = i == 0 ? q0.size() > 0 : q1.size() > 0;
        if (!have) chk("spurious_done", 1, 0);
        else begin
          e = i == 0 ? q0.pop_front() : q1.pop_front();
          chk("serial_data", int'(bits[i]), int'(e.w));
          chk("tb_count", tbn[i], 9);
          chk("done_cycle", cyc, e.due);
          chk("first_tb_to_done", cyc - first_tb[i], 9 * per(i));
          chk("delimiter_bit", int'(delim[i]), 0);
          chk("protocol", int'(perr[i]), 0);
        end
        tbn[i] = 0;
        perr[i] = 1'b0;
      end
    end
    rst_d[i] = rst[i];
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon(i);
    if (fin && !fin_seen) begin
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      fin_seen = 1'b1;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    din[0] = '0;
    din[1] = '0;
    fork
      begin
        din[0] = 8'hA5;
        vld[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        send(0, 8'hA5, -1, 1'b1, ta);
        send(0, 8'hFF, -1, 1'b1, ta);
        send(0, 8'h00, ta + 20, 1'b1, ta);
        send(0, 8'hC3, -1, 1'b0, tr);
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        send(0, 8'h5A, tr + 15, 1'b1, ta);
        repeat (14) @(posedge clk);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        rst[1] = 1'b0;
        send(1, 8'h81, -1, 1'b1, tb_acc);
        repeat (5) @(posedge clk);
        #1;
        din[1] = 8'h3C;
        vld[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vld[1] = 1'b0;
        send(1, 8'h6E, tb_acc + 74, 1'b1, tb_acc);
        repeat (45) @(posedge clk);
      end
    join
    fin = 1'b1;
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
